// File: rtl/text_pkg.sv
// Shared constants, FSM state type and helpers for the HUD text line scheduler.
// Leading-zero behaviour is selected in the top by TEXT_LEADING_ZERO_EN.
package text_pkg;

  localparam int DEFAULT_NUM_DIGITS = 6;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    WRITE
  } text_sched_state_t;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned dec_max(input int digits);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: saturates the input to the largest NUM_DIGITS-digit
// decimal, then converts one bit per cycle; done is high during the final shift.
module bin2bcd_seq
  import text_pkg::*;
#(
  parameter int VAL_W      = 20,
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VAL_W-1:0]        value,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam longint unsigned SAT_VAL = dec_max(NUM_DIGITS);
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]        bin_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]        cnt_q;
  logic                    run_q;
  logic [VAL_W-1:0]        sat_val;

  always_comb begin
    sat_val = value;
    if (64'(value) > SAT_VAL) begin
      sat_val = VAL_W'(SAT_VAL);
    end
  end

  // Add-3 correction on every digit that would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
  end

  assign done = run_q && (cnt_q == CNT_W'(VAL_W - 1));
  assign bcd  = bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      bin_q <= sat_val;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      bcd_q <= {bcd_adj[4*NUM_DIGITS-2:0], bin_q[VAL_W-1]};
      bin_q <= {bin_q[VAL_W-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/text_line_sched.sv
// HUD text line scheduler: round-robin grant, BCD conversion, shadow write, vblank commit.
// Build option: TEXT_LEADING_ZERO_EN draws leading zeros instead of blanking them.
module text_line_sched
  import text_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int VAL_W      = 20,
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vblank,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*VAL_W-1:0]        req_value,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [$clog2(N_REQ)-1:0]      rd_line,
  input  logic [$clog2(NUM_DIGITS)-1:0] rd_col,
  output logic [7:0]                    rd_char,
  output logic                          busy
);

  localparam int LINE_W = $clog2(N_REQ);
  localparam int COL_W  = $clog2(NUM_DIGITS);

  function automatic logic [7:0] reset_char(input int col);
`ifdef TEXT_LEADING_ZERO_EN
    return (col >= 0) ? ASCII_ZERO : ASCII_SPACE;
`else
    return (col == NUM_DIGITS - 1) ? ASCII_ZERO : ASCII_SPACE;
`endif
  endfunction

  text_sched_state_t state_q, state_nxt;

  logic [LINE_W-1:0]       rr_ptr_q;
  logic [LINE_W-1:0]       g_q;
  logic [COL_W-1:0]        col_q;
  logic [N_REQ-1:0]        dirty_q;
  logic                    vblank_q;
  logic [7:0]              shadow_q [N_REQ][NUM_DIGITS];
  logic [7:0]              front_q  [N_REQ][NUM_DIGITS];

  logic                    gnt_vld;
  logic [LINE_W-1:0]       gnt_idx;
  logic [LINE_W-1:0]       cand;
  logic [VAL_W-1:0]        gnt_value;
  logic                    conv_start;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [3:0]              wr_digit;
  logic                    lead_zero;
  logic [7:0]              wr_char;
  logic                    last_col;
  logic                    vblank_rise;

  // Round-robin search: iterate downward so the closest requester above rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = LINE_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_value = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (LINE_W'(i) == gnt_idx) begin
        gnt_value = req_value[i*VAL_W +: VAL_W];
      end
    end
  end

  bin2bcd_seq #(
    .VAL_W      (VAL_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (gnt_value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign last_col    = (col_q == COL_W'(NUM_DIGITS - 1));
  assign vblank_rise = vblank && !vblank_q;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Ready is gated by rst so the accept pulse never leaks while reset is held.
  always_comb begin
    state_nxt  = state_q;
    req_ready  = '0;
    conv_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          conv_start         = 1'b1;
          state_nxt          = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (last_col) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column 0 is the most significant digit; blank zeros until the first non-zero one.
  always_comb begin
    wr_digit  = '0;
    lead_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j <= int'(col_q)) && (bcd[4*(NUM_DIGITS-1-j) +: 4] != 4'd0)) begin
        lead_zero = 1'b0;
      end
      if (j == int'(col_q)) begin
        wr_digit = bcd[4*(NUM_DIGITS-1-j) +: 4];
      end
    end
    wr_char = ASCII_ZERO + {4'd0, wr_digit};
`ifndef TEXT_LEADING_ZERO_EN
    if (lead_zero && !last_col) begin
      wr_char = ASCII_SPACE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      g_q      <= '0;
      col_q    <= '0;
      dirty_q  <= '0;
      vblank_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        for (int c = 0; c < NUM_DIGITS; c++) begin
          shadow_q[i][c] <= reset_char(c);
          front_q[i][c]  <= reset_char(c);
        end
      end
    end else begin
      vblank_q <= vblank;
      if (conv_start) begin
        g_q      <= gnt_idx;
        rr_ptr_q <= (gnt_idx == LINE_W'(N_REQ - 1)) ? '0 : gnt_idx + LINE_W'(1);
      end
      if (state_q == CONV) begin
        col_q <= '0;
      end
      // The line under rewrite is held back so the front never sees a partial line.
      for (int i = 0; i < N_REQ; i++) begin
        if (vblank_rise && dirty_q[i] && !(busy && (LINE_W'(i) == g_q))) begin
          dirty_q[i] <= 1'b0;
          for (int c = 0; c < NUM_DIGITS; c++) begin
            front_q[i][c] <= shadow_q[i][c];
          end
        end
      end
      if (state_q == WRITE) begin
        shadow_q[g_q][col_q] <= wr_char;
        col_q                <= col_q + COL_W'(1);
        if (last_col) begin
          dirty_q[g_q] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_char = ASCII_SPACE;
    if ((int'(rd_line) < N_REQ) && (int'(rd_col) < NUM_DIGITS)) begin
      rd_char = front_q[rd_line][rd_col];
    end
  end

endmodule

// File: tb/tb_text_line_sched.sv
// Randomised and directed bench for text_line_sched with a timing-level reference model.
module tb_text_line_sched;

  logic        clk;
  logic        rst;
  logic        vblank;
  logic [2:0]  req_valid;
  logic [59:0] req_value;
  logic [2:0]  req_ready;
  logic [1:0]  rd_line;
  logic [2:0]  rd_col;
  logic [7:0]  rd_char;
  logic        busy;

  text_line_sched dut (
    .clk       (clk),
    .rst       (rst),
    .vblank    (vblank),
    .req_valid (req_valid),
    .req_value (req_value),
    .req_ready (req_ready),
    .rd_line   (rd_line),
    .rd_col    (rd_col),
    .rd_char   (rd_char),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  bit          hold  [3];
  bit          rearm [3];
  logic [19:0] val   [3];

  // Reference model state
  logic [7:0]  m_front  [3][6];
  logic [7:0]  m_shadow [3][6];
  bit          m_dirty  [3];
  int          gnt_t;
  int          cur_g;
  logic [19:0] cur_val;
  int          rr;
  bit          vb_prev;

  logic [2:0]  last_rdy;
  logic        last_busy;
  logic [7:0]  last_rd;
  int          gq_idx [$];
  int          gq_t   [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  function automatic logic [7:0] fmt_char(input int unsigned v_in, input int c);
    int unsigned v;
    int unsigned p;
    v = (v_in > 999999) ? 999999 : v_in;
    p = 1;
    for (int k = 0; k < 5 - c; k++) p = p * 10;
`ifndef TEXT_LEADING_ZERO_EN
    if (c != 5 && v < p) return 8'h20;
`endif
    return 8'h30 + 8'((v / p) % 10);
  endfunction

  function automatic logic [7:0] model_read(input int l, input int c);
    if (l >= 3 || c >= 6) return 8'h20;
    return m_front[l][c];
  endfunction

  function automatic logic [19:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 20'($urandom_range(0, 99));
      1:       return 20'($urandom_range(0, 999999));
      2:       return 20'hFFFFF;
      default: return 20'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_dirty[i] = 1'b0;
      for (int c = 0; c < 6; c++) begin
        m_front[i][c]  = fmt_char(0, c);
        m_shadow[i][c] = fmt_char(0, c);
      end
    end
    gnt_t   = -1000;
    cur_g   = 0;
    cur_val = '0;
    rr      = 0;
    vb_prev = 1'b0;
  endtask

  // An update granted at cycle T is busy for T+1..T+26 and its line is complete at T+27.
  task automatic model_cycle();
    int g;
    logic [2:0] exp_rdy;
    bit mb;
    if (t == gnt_t + 27) begin
      m_dirty[cur_g] = 1'b1;
      for (int c = 0; c < 6; c++) m_shadow[cur_g][c] = fmt_char(cur_val, c);
    end
    mb = (t > gnt_t) && (t < gnt_t + 27);
    g = -1;
    exp_rdy = '0;
    if (!mb) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (rr + k) % 3;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("busy", 32'(busy), 32'(mb));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rd_char", 32'(rd_char), 32'(model_read(int'(rd_line), int'(rd_col))));
    if (vblank && !vb_prev) begin
      for (int i = 0; i < 3; i++) begin
        if (m_dirty[i] && !(mb && i == cur_g)) begin
          m_dirty[i] = 1'b0;
          for (int c = 0; c < 6; c++) m_front[i][c] = m_shadow[i][c];
        end
      end
    end
    vb_prev = vblank;
    if (g >= 0) begin
      gnt_t   = t;
      cur_g   = g;
      cur_val = val[g];
      rr      = (g + 1) % 3;
      if (rearm[g]) val[g] = rand_val();
      else hold[g] = 1'b0;
    end
  endtask

  task automatic step();
    req_valid = {hold[2], hold[1], hold[0]};
    req_value = {val[2], val[1], val[0]};
    #1;
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      model_reset();
    end else begin
      model_cycle();
      if (req_ready != 3'b000) begin
        for (int i = 0; i < 3; i++) begin
          if (req_ready[i]) begin
            gq_idx.push_back(i);
            gq_t.push_back(t);
          end
        end
      end
    end
    last_rdy  = req_ready;
    last_busy = busy;
    last_rd   = rd_char;
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_at(input int l, input int c);
    rd_line = 2'(l);
    rd_col  = 3'(c);
    step();
  endtask

  task automatic vblank_pulse();
    vblank = 1'b1;
    step();
    vblank = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  string s_12345, s_321, s_sat, s_col0;
  int busy_cnt;

  initial begin
`ifdef TEXT_LEADING_ZERO_EN
    s_12345 = "012345";
    s_321   = "000321";
    s_col0  = "0";
`else
    s_12345 = " 12345";
    s_321   = "   321";
    s_col0  = " ";
`endif
    s_sat = "999999";
    rst = 1'b1;
    vblank = 1'b0;
    rd_line = '0;
    rd_col = '0;
    for (int i = 0; i < 3; i++) begin
      hold[i] = 1'b0;
      rearm[i] = 1'b0;
      val[i] = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset contents of the front buffer
    read_at(1, 0);
    chk("reset_col0", 32'(last_rd), 32'(s_col0[0]));
    read_at(1, 5);
    chk("reset_col5", 32'(last_rd), 32'h30);

    // Single update of line 1
    hold[1] = 1'b1;
    val[1]  = 20'd12345;
    step();
    chk("single_ready", 32'(last_rdy), 32'b010);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_busy) busy_cnt++;
    end
    chk("single_busy_len", 32'(busy_cnt), 32'd26);
    read_at(1, 1);
    chk("single_pre_vblank", 32'(last_rd), 32'(s_col0[0]));
    vblank_pulse();
    for (int c = 0; c < 6; c++) begin
      read_at(1, c);
      chk("single_line", 32'(last_rd), 32'(s_12345[c]));
    end

    // Saturation on line 2
    hold[2] = 1'b1;
    val[2]  = 20'hFFFFF;
    steps(30);
    vblank_pulse();
    for (int c = 0; c < 6; c++) begin
      read_at(2, c);
      chk("saturate", 32'(last_rd), 32'(s_sat[c]));
    end

    // Round-robin with all requesters continuously valid from reset
    for (int i = 0; i < 3; i++) begin
      hold[i] = 1'b1;
      rearm[i] = 1'b1;
      val[i] = rand_val();
    end
    do_reset();
    gq_idx.delete();
    gq_t.delete();
    steps(90);
    hold[1] = 1'b0;
    rearm[1] = 1'b0;
    steps(30);
    if (gq_idx.size() >= 5) begin
      chk("rr_g0", 32'(gq_idx[0]), 32'd0);
      chk("rr_g1", 32'(gq_idx[1]), 32'd1);
      chk("rr_g2", 32'(gq_idx[2]), 32'd2);
      chk("rr_g3", 32'(gq_idx[3]), 32'd0);
      chk("rr_skip", 32'(gq_idx[4]), 32'd2);
      for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(gq_t[k] - gq_t[k-1]), 32'd27);
    end else begin
      chk("rr_grant_count", 32'(gq_idx.size()), 32'd5);
    end
    for (int i = 0; i < 3; i++) begin
      hold[i] = 1'b0;
      rearm[i] = 1'b0;
    end
    steps(30);

    // Commit collision on line 0
    do_reset();
    hold[0] = 1'b1;
    val[0]  = 20'd7;
    step();
    hold[0] = 1'b1;
    val[0]  = 20'd99;
    steps(49);
    vblank_pulse();
    read_at(0, 5);
    chk("collision_hold", 32'(last_rd), 32'h30);
    steps(10);
    vblank_pulse();
    read_at(0, 4);
    chk("collision_d4", 32'(last_rd), 32'h39);
    read_at(0, 5);
    chk("collision_d5", 32'(last_rd), 32'h39);

    // Reset in the middle of a conversion
    hold[2] = 1'b1;
    val[2]  = 20'd555;
    step();
    steps(5);
    do_reset();
    read_at(2, 5);
    chk("midreset_line", 32'(last_rd), 32'h30);
    hold[2] = 1'b1;
    val[2]  = 20'd321;
    steps(30);
    vblank_pulse();
    for (int c = 0; c < 6; c++) begin
      read_at(2, c);
      chk("after_reset_update", 32'(last_rd), 32'(s_321[c]));
    end

    // Out-of-range reads
    read_at(3, 0);
    chk("bound_line", 32'(last_rd), 32'h20);
    read_at(0, 6);
    chk("bound_col", 32'(last_rd), 32'h20);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!hold[i] && $urandom_range(0, 19) == 0) begin
          hold[i] = 1'b1;
          val[i] = rand_val();
        end
      end
      vblank  = ((t % 73) >= 60);
      rd_line = 2'($urandom_range(0, 3));
      rd_col  = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
